// File: rtl/gemm_lane_engine.sv
// gemm_lane_engine: NumLanes parallel signed MACs computing NumLanes adjacent
// C columns per tile. A is one element per word; B and C are packed
// NumLanes elements per word. Tiles are visited m outer, t inner; each tile
// streams k = 0..K-1 and takes K+2 cycles (K issue, one drain, one write).
// Optional feature macro: GEMM_LANE_ENGINE_PERF_EN (busy-cycle counter on
// perf_cycles_o); when undefined perf_cycles_o is tied to 0.

// One MAC lane: accumulator plus the tail write-mask bit for its column.
module gemm_lane_mac #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int ColW         = 11,
  parameter int LaneIdx      = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           vld_i,
  input  logic                           first_i,
  input  logic signed [InDataWidth-1:0]  a_i,
  input  logic signed [InDataWidth-1:0]  b_i,
  input  logic        [ColW-1:0]         col_i,
  input  logic        [ColW-1:0]         n_i,
  output logic        [OutDataWidth-1:0] acc_o,
  output logic                           mask_o
);
  logic signed [2*InDataWidth-1:0] prod;
  logic signed [OutDataWidth-1:0]  prod_ext;
  logic        [OutDataWidth-1:0]  acc_d, acc_q;

  assign prod     = a_i * b_i;
  assign prod_ext = OutDataWidth'(prod);

  // First beat of a tile loads the product, later beats add (wrapping).
  always_comb begin
    acc_d = acc_q;
    if (vld_i) acc_d = first_i ? prod_ext : acc_q + prod_ext;
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o  = acc_q;
  assign mask_o = (col_i + ColW'(LaneIdx)) < n_i;
endmodule

module gemm_lane_engine #(
  parameter int InDataWidth   = 8,
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8,
  parameter int NumLanes      = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [SizeAddrWidth-1:0]          M_size_i,
  input  logic [SizeAddrWidth-1:0]          K_size_i,
  input  logic [SizeAddrWidth-1:0]          N_size_i,
  output logic [AddrWidth-1:0]              sram_a_addr_o,
  input  logic [InDataWidth-1:0]            sram_a_rdata_i,
  output logic [AddrWidth-1:0]              sram_b_addr_o,
  input  logic [NumLanes*InDataWidth-1:0]   sram_b_rdata_i,
  output logic [AddrWidth-1:0]              sram_c_addr_o,
  output logic [NumLanes*OutDataWidth-1:0]  sram_c_wdata_o,
  output logic                              sram_c_we_o,
  output logic [NumLanes-1:0]               sram_c_wmask_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [31:0]                       perf_cycles_o
);
  localparam int LaneBits = (NumLanes > 1) ? $clog2(NumLanes) : 0;
  localparam int ColW     = SizeAddrWidth + LaneBits + 1;
  localparam int SW       = SizeAddrWidth;

  typedef enum logic [2:0] {IDLE, RUN, LAST, WRITE, DONE} state_e;

  state_e            state_d, state_q;
  logic [SW-1:0]     m_sz_d, m_sz_q, k_sz_d, k_sz_q, n_sz_d, n_sz_q, nw_d, nw_q;
  logic [SW-1:0]     k_cnt_d, k_cnt_q, t_cnt_d, t_cnt_q, m_cnt_d, m_cnt_q;
  logic [AddrWidth-1:0] a_addr_d, a_addr_q, b_addr_d, b_addr_q;
  logic [AddrWidth-1:0] c_addr_d, c_addr_q, a_base_d, a_base_q;
  logic [ColW-1:0]   col_d, col_q;
  logic              vld_d, vld_q, first_d, first_q;
  logic [SW:0]       nw_wide;
  logic              accept;

  logic [NumLanes-1:0][OutDataWidth-1:0] acc;
  logic [NumLanes-1:0]                   mask;

  assign accept  = (state_q == IDLE) && start_i;
  assign nw_wide = ({1'b0, N_size_i} + (SW+1)'(NumLanes-1)) >> LaneBits;

  // Next-state, counters and address generation.
  always_comb begin
    state_d  = state_q;
    m_sz_d   = m_sz_q;
    k_sz_d   = k_sz_q;
    n_sz_d   = n_sz_q;
    nw_d     = nw_q;
    k_cnt_d  = k_cnt_q;
    t_cnt_d  = t_cnt_q;
    m_cnt_d  = m_cnt_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    a_base_d = a_base_q;
    col_d    = col_q;
    vld_d    = 1'b0;
    first_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          m_sz_d = M_size_i;
          k_sz_d = K_size_i;
          n_sz_d = N_size_i;
          nw_d   = nw_wide[SW-1:0];
          if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) begin
            state_d = DONE;
          end else begin
            state_d  = RUN;
            k_cnt_d  = '0;
            t_cnt_d  = '0;
            m_cnt_d  = '0;
            a_addr_d = '0;
            b_addr_d = '0;
            c_addr_d = '0;
            a_base_d = '0;
            col_d    = '0;
          end
        end
      end
      RUN: begin
        vld_d   = 1'b1;
        first_d = (k_cnt_q == '0);
        if (k_cnt_q == k_sz_q - SW'(1)) begin
          state_d = LAST;
        end else begin
          k_cnt_d  = k_cnt_q + SW'(1);
          a_addr_d = a_addr_q + AddrWidth'(1);
          b_addr_d = b_addr_q + AddrWidth'(nw_q);
        end
      end
      LAST: state_d = WRITE;
      WRITE: begin
        state_d = RUN;
        k_cnt_d = '0;
        if (t_cnt_q == nw_q - SW'(1)) begin
          t_cnt_d = '0;
          col_d   = '0;
          if (m_cnt_q == m_sz_q - SW'(1)) begin
            state_d = DONE;
          end else begin
            m_cnt_d  = m_cnt_q + SW'(1);
            a_base_d = a_base_q + AddrWidth'(k_sz_q);
            a_addr_d = a_base_q + AddrWidth'(k_sz_q);
            b_addr_d = '0;
          end
        end else begin
          t_cnt_d  = t_cnt_q + SW'(1);
          col_d    = col_q + ColW'(NumLanes);
          a_addr_d = a_base_q;
          b_addr_d = AddrWidth'(t_cnt_q) + AddrWidth'(1);
        end
        // C address stays on the final word once the run completes.
        if (state_d == RUN) c_addr_d = c_addr_q + AddrWidth'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers; reset wins over a same-cycle start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      m_sz_q   <= '0;
      k_sz_q   <= '0;
      n_sz_q   <= '0;
      nw_q     <= '0;
      k_cnt_q  <= '0;
      t_cnt_q  <= '0;
      m_cnt_q  <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      a_base_q <= '0;
      col_q    <= '0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_sz_q   <= m_sz_d;
      k_sz_q   <= k_sz_d;
      n_sz_q   <= n_sz_d;
      nw_q     <= nw_d;
      k_cnt_q  <= k_cnt_d;
      t_cnt_q  <= t_cnt_d;
      m_cnt_q  <= m_cnt_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      a_base_q <= a_base_d;
      col_q    <= col_d;
      vld_q    <= vld_d;
      first_q  <= first_d;
    end
  end

  // SRAM read data lands one cycle after issue, so the beat flags are the
  // issue flags delayed by one register.
  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    gemm_lane_mac #(
      .InDataWidth (InDataWidth),
      .OutDataWidth(OutDataWidth),
      .ColW        (ColW),
      .LaneIdx     (l)
    ) u_mac (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .vld_i  (vld_q),
      .first_i(first_q),
      .a_i    (sram_a_rdata_i),
      .b_i    (sram_b_rdata_i[l*InDataWidth +: InDataWidth]),
      .col_i  (col_q),
      .n_i    (ColW'(n_sz_q)),
      .acc_o  (acc[l]),
      .mask_o (mask[l])
    );
  end

  assign sram_a_addr_o  = a_addr_q;
  assign sram_b_addr_o  = b_addr_q;
  assign sram_c_addr_o  = c_addr_q;
  assign sram_c_wdata_o = acc;
  assign sram_c_we_o    = (state_q == WRITE);
  assign sram_c_wmask_o = sram_c_we_o ? mask : '0;
  assign busy_o         = (state_q == RUN) || (state_q == LAST) || (state_q == WRITE);
  assign done_o         = (state_q == DONE);

`ifdef GEMM_LANE_ENGINE_PERF_EN
  logic [31:0] perf_d, perf_q;

  // Clear on accepted start, count busy cycles, hold otherwise.
  always_comb begin
    perf_d = perf_q;
    if (accept)      perf_d = '0;
    else if (busy_o) perf_d = perf_q + 32'd1;
  end

  // Perf counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign perf_cycles_o = '0;
`endif
endmodule

// File: tb/tb_gemm_lane_engine.sv
// Directed bench for gemm_lane_engine: SRAM models with one-cycle read
// latency, a golden GEMM over the bench's own A/B arrays, and hand-computed
// constants for the identity, tail, signed-extreme, zero-size, start-while-busy
// and reset-abort scenarios.
module tb_gemm_lane_engine;
  localparam int IW = 8, OW = 32, AW = 12, SW = 8, NL = 4;

  logic              clk = 1'b0;
  logic              rst_i, start_i;
  logic [SW-1:0]     M_size_i, K_size_i, N_size_i;
  logic [AW-1:0]     sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
  logic [IW-1:0]     sram_a_rdata_i;
  logic [NL*IW-1:0]  sram_b_rdata_i;
  logic [NL*OW-1:0]  sram_c_wdata_o;
  logic              sram_c_we_o, busy_o, done_o;
  logic [NL-1:0]     sram_c_wmask_o;
  logic [31:0]       perf_cycles_o;

  gemm_lane_engine #(
    .InDataWidth(IW), .OutDataWidth(OW), .AddrWidth(AW),
    .SizeAddrWidth(SW), .NumLanes(NL)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
    .sram_a_addr_o(sram_a_addr_o), .sram_a_rdata_i(sram_a_rdata_i),
    .sram_b_addr_o(sram_b_addr_o), .sram_b_rdata_i(sram_b_rdata_i),
    .sram_c_addr_o(sram_c_addr_o), .sram_c_wdata_o(sram_c_wdata_o),
    .sram_c_we_o(sram_c_we_o), .sram_c_wmask_o(sram_c_wmask_o),
    .busy_o(busy_o), .done_o(done_o), .perf_cycles_o(perf_cycles_o)
  );

  always #5 clk = ~clk;

  logic [IW-1:0]    mem_a [4096];
  logic [NL*IW-1:0] mem_b [4096];
  logic [NL*OW-1:0] mem_c [4096];

  // Synchronous-read SRAMs and masked C write port.
  always @(posedge clk) begin
    sram_a_rdata_i <= mem_a[sram_a_addr_o];
    sram_b_rdata_i <= mem_b[sram_b_addr_o];
    if (sram_c_we_o)
      for (int l = 0; l < NL; l++)
        if (sram_c_wmask_o[l]) mem_c[sram_c_addr_o][l*OW +: OW] <= sram_c_wdata_o[l*OW +: OW];
  end

  int we_cnt = 0, done_cnt = 0, busy_cnt = 0;
  logic [NL-1:0] masks[$];

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (sram_c_we_o) begin
      we_cnt++;
      masks.push_back(sram_c_wmask_o);
    end
    if (done_o) done_cnt++;
    if (busy_o) busy_cnt++;
  end

  int n_chk = 0, n_fail = 0;
  int mq0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gold(input int m, input int n, input int k_sz, input int n_sz);
    int nw;
    logic signed [31:0] s;
    logic [NL*IW-1:0] bw;
    nw = (n_sz + NL - 1) / NL;
    s = 0;
    for (int k = 0; k < k_sz; k++) begin
      bw = mem_b[k*nw + n/NL];
      s += $signed(mem_a[m*k_sz + k]) * $signed(bw[(n%NL)*IW +: IW]);
    end
    return s;
  endfunction

  task automatic start_run(input int m, input int k, input int n);
    @(negedge clk);
    M_size_i = SW'(m); K_size_i = SW'(k); N_size_i = SW'(n);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Bounded wait for done; optionally pulses start_i at cycle 'poke'.
  task automatic wait_done(input int poke, output int lat);
    lat = 1;
    while (!done_o && lat < 5000) begin
      start_i = (lat == poke);
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    chk("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  task automatic clear_c();
    for (int i = 0; i < 4096; i++) mem_c[i] = '0;
  endtask

  task automatic do_test(input string nm, input int m, input int k, input int n, input int poke);
    int nw, lat, we0, dn0, t;
    logic [31:0] perf_at_done, pexp;
    logic [NL-1:0] mexp;
    nw = (n + NL - 1) / NL;
    clear_c();
    we0 = we_cnt; dn0 = done_cnt; mq0 = masks.size();
    start_run(m, k, n);
    wait_done(poke, lat);
    perf_at_done = perf_cycles_o;
    chk({nm, "_latency"}, lat, m*nw*(k+2) + 1);
`ifdef GEMM_LANE_ENGINE_PERF_EN
    pexp = lat - 1;
`else
    pexp = 0;
`endif
    chk({nm, "_perf"}, perf_at_done, pexp);
    repeat (3) @(negedge clk);
    chk({nm, "_perf_hold"}, perf_cycles_o, pexp);
    chk({nm, "_writes"}, we_cnt - we0, m*nw);
    chk({nm, "_dones"}, done_cnt - dn0, 1);
    for (int i = 0; i < m*nw && mq0 + i < masks.size(); i++) begin
      t = i % nw;
      for (int l = 0; l < NL; l++) mexp[l] = (t*NL + l < n);
      chk($sformatf("%s_mask%0d", nm, i), masks[mq0+i], mexp);
    end
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        chk($sformatf("%s_c%0d_%0d", nm, r, c), mem_c[r*nw + c/NL][(c%NL)*OW +: OW], gold(r, c, k, n));
  endtask

  initial begin
    logic [AW-1:0] sa, sb, sc;
    int we0, dn0, bz0, lat;

    rst_i = 1'b1; start_i = 1'b0;
    M_size_i = '0; K_size_i = '0; N_size_i = '0;
    for (int i = 0; i < 4096; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    clear_c();
    repeat (3) @(negedge clk);
    chk("rst_a_addr", 32'(sram_a_addr_o), 0);
    chk("rst_b_addr", 32'(sram_b_addr_o), 0);
    chk("rst_c_addr", 32'(sram_c_addr_o), 0);
    chk("rst_we",     {31'd0, sram_c_we_o}, 0);
    chk("rst_mask",   32'(sram_c_wmask_o), 0);
    chk("rst_wdata",  sram_c_wdata_o[31:0] | sram_c_wdata_o[127:96], 0);
    chk("rst_busy",   {31'd0, busy_o}, 0);
    chk("rst_done",   {31'd0, done_o}, 0);
    chk("rst_perf",   perf_cycles_o, 0);
    rst_i = 1'b0;

    // Identity: C rows equal B rows.
    for (int i = 0; i < 16; i++) mem_a[i] = (i/4 == i%4) ? 8'd1 : 8'd0;
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < NL; l++) mem_b[k][l*IW +: IW] = IW'(4*k + l + 1);
    do_test("ident", 4, 4, 4, 0);
    for (int m = 0; m < 4; m++)
      for (int l = 0; l < NL; l++)
        chk($sformatf("ident_hand%0d_%0d", m, l), mem_c[m][l*OW +: OW], 4*m + l + 1);

    // N tail: NW=2, odd writes partially masked.
    for (int i = 0; i < 6; i++) mem_a[i] = 8'd1;
    for (int w = 0; w < 6; w++)
      for (int l = 0; l < NL; l++) mem_b[w][l*IW +: IW] = IW'(l + 1);
    do_test("tail", 2, 3, 6, 0);
    chk("tail_mask_odd1", masks[mq0+1], 4'b0011);
    chk("tail_mask_odd3", masks[mq0+3], 4'b0011);
    chk("tail_mask_even", masks[mq0+2], 4'b1111);
    chk("tail_hand_c1_1", mem_c[2][1*OW +: OW], 6);
    chk("tail_hand_c1_5", mem_c[3][1*OW +: OW], 6);
    chk("tail_hand_c0_3", mem_c[0][3*OW +: OW], 12);

    // Signed extremes over K=64.
    for (int k = 0; k < 64; k++) begin
      mem_a[k] = 8'h80;
      mem_b[k] = {8'h55, 8'h55, 8'h55, 8'h80};
    end
    do_test("neg_neg", 1, 64, 1, 0);
    chk("neg_neg_hand", mem_c[0][OW-1:0], 32'd1048576);
    for (int k = 0; k < 64; k++) mem_b[k][IW-1:0] = 8'h7f;
    do_test("neg_pos", 1, 64, 1, 0);
    chk("neg_pos_hand", mem_c[0][OW-1:0], -32'sd1040384);

    // Zero size: immediate done, no SRAM activity.
    sa = sram_a_addr_o; sb = sram_b_addr_o; sc = sram_c_addr_o;
    we0 = we_cnt; dn0 = done_cnt; bz0 = busy_cnt;
    start_run(4, 0, 4);
    chk("zero_done_next", {31'd0, done_o}, 1);
    repeat (4) @(negedge clk);
    chk("zero_writes", we_cnt - we0, 0);
    chk("zero_busy", busy_cnt - bz0, 0);
    chk("zero_dones", done_cnt - dn0, 1);
    chk("zero_addr", {sram_a_addr_o, sram_b_addr_o, sram_c_addr_o}, {sa, sb, sc});

    // Start while busy is ignored.
    for (int i = 0; i < 64; i++) begin mem_a[i] = IW'($urandom); mem_b[i] = $urandom; end
    do_test("busy_start", 2, 4, 8, 5);

    // Reset during the second tile aborts; same-cycle start is ignored.
    we0 = we_cnt;
    start_run(8, 8, 8);
    repeat (14) @(negedge clk);
    chk("abort_first_tile_written", we_cnt - we0, 1);
    rst_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; start_i = 1'b0;
    chk("abort_outputs_zero", {20'd0, sram_a_addr_o} | 32'(sram_b_addr_o) | 32'(sram_c_addr_o)
        | {29'd0, sram_c_we_o, busy_o, done_o} | 32'(sram_c_wmask_o) | perf_cycles_o, 0);
    chk("abort_wdata_zero", sram_c_wdata_o[31:0] | sram_c_wdata_o[63:32], 0);
    we0 = we_cnt; dn0 = done_cnt; bz0 = busy_cnt;
    repeat (200) @(negedge clk);
    chk("abort_no_writes", we_cnt - we0, 0);
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_no_busy", busy_cnt - bz0, 0);
    do_test("after_abort", 8, 8, 8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
